// File: rtl/clk_div_detect.sv
// Measures half-periods of an asynchronous divided clock, tracks lock to the
// nominal rate and reports edges, lock state and loss-of-lock events.
module clk_div_detect #(
    parameter int HALF_PERIOD = 64,
    parameter int TOL         = 4,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             sig_in,
    output logic             edge_out,
    output logic             rise_out,
    output logic             locked_out,
    output logic             error_out,
    output logic [CNT_W-1:0] half_period_out
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] LOW_LIM  = CNT_W'(HALF_PERIOD - TOL);
    localparam logic [CNT_W-1:0] HIGH_LIM = CNT_W'(HALF_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(HALF_PERIOD + TOL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [GW-1:0]    LAST_GOOD = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED
    } state_t;

    state_t          state, next_state;
    logic [GW-1:0]   good_cnt, next_good_cnt;
    logic [CNT_W-1:0] cnt;
    logic            s1, s2, s3;
    logic            trans, rising, good, timeout;

    // cnt holds the elapsed cycles including the current one, so on a
    // transition it already equals the measured half-period.
    always_comb begin
        trans         = s2 ^ s3;
        rising        = s2 & ~s3;
        good          = trans && (cnt >= LOW_LIM) && (cnt <= HIGH_LIM);
        timeout       = !trans && (cnt >= TMO_LIM);
        next_state    = state;
        next_good_cnt = good_cnt;
        case (state)
            IDLE: begin
                if (trans) begin
                    next_state    = TRACK;
                    next_good_cnt = '0;
                end
            end
            TRACK: begin
                if (trans) begin
                    if (good) begin
                        if (good_cnt == LAST_GOOD) begin
                            next_state    = LOCKED;
                            next_good_cnt = '0;
                        end else begin
                            next_good_cnt = good_cnt + 1'b1;
                        end
                    end else begin
                        next_good_cnt = '0;
                    end
                end else if (timeout) begin
                    next_state    = IDLE;
                    next_good_cnt = '0;
                end
            end
            LOCKED: begin
                if (trans && !good) begin
                    next_state    = TRACK;
                    next_good_cnt = '0;
                end else if (timeout) begin
                    next_state    = IDLE;
                    next_good_cnt = '0;
                end
            end
            default: begin
                next_state    = IDLE;
                next_good_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            s1              <= 1'b0;
            s2              <= 1'b0;
            s3              <= 1'b0;
            edge_out        <= 1'b0;
            rise_out        <= 1'b0;
            locked_out      <= 1'b0;
            error_out       <= 1'b0;
            half_period_out <= '0;
            cnt             <= '0;
            good_cnt        <= '0;
            state           <= IDLE;
        end else begin
            s1         <= sig_in;
            s2         <= s1;
            s3         <= s2;
            edge_out   <= trans;
            rise_out   <= rising;
            locked_out <= (next_state == LOCKED);
            error_out  <= (state == LOCKED) && (next_state != LOCKED);
            state      <= next_state;
            good_cnt   <= next_good_cnt;
            // The reference edge taken in IDLE is not a measurement.
            if (trans) begin
                cnt <= CNT_W'(1);
                if (state != IDLE) begin
                    half_period_out <= cnt;
                end
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_detect.sv
// Directed bench for clk_div_detect: latency, lock acquisition, tolerance,
// timeout, glitch and reset behaviour with hand-computed expectations.
module tb_clk_div_detect;

    logic       clk_in;
    logic       rst_n_in;
    logic       sig_in;
    logic       edge_out;
    logic       rise_out;
    logic       locked_out;
    logic       error_out;
    logic [7:0] half_period_out;

    int checks = 0;
    int errors = 0;

    int edge_count      = 0;
    int lock_rise_edge  = -1;
    int err_pulses      = 0;
    int err_wide        = 0;
    int err_incoherent  = 0;
    logic prev_locked   = 1'b0;
    logic prev_err      = 1'b0;

    clk_div_detect #(
        .HALF_PERIOD(64),
        .TOL(4),
        .LOCK_COUNT(4),
        .CNT_W(8)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .sig_in(sig_in),
        .edge_out(edge_out),
        .rise_out(rise_out),
        .locked_out(locked_out),
        .error_out(error_out),
        .half_period_out(half_period_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Event monitor, sampled shortly after each rising edge so task checks at
    // the falling edge always see settled counts.
    always @(posedge clk_in) begin
        #2;
        if (edge_out) edge_count++;
        if (locked_out && !prev_locked) lock_rise_edge = edge_count;
        if (error_out) begin
            err_pulses++;
            if (prev_err) err_wide++;
            if (locked_out || !prev_locked) err_incoherent++;
        end
        prev_locked = locked_out;
        prev_err    = error_out;
    end

    // Toggle sig_in and hold the new level for n sampling edges.
    task automatic half_period(input int n);
        @(negedge clk_in);
        sig_in = ~sig_in;
        repeat (n - 1) @(negedge clk_in);
    endtask

    task automatic test_reset;
        rst_n_in = 1'b0;
        sig_in   = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (locked_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", locked_out); end
        checks++;
        if (half_period_out !== 8'd0) begin errors++; $display("[TB] FAIL reset_hp: got %0d expected 0", half_period_out); end
        checks++;
        if ({edge_out, rise_out, error_out} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 000", {edge_out, rise_out, error_out}); end
        rst_n_in   = 1'b1;
        edge_count = 0;
        repeat (10) @(negedge clk_in);
        checks++;
        if ({locked_out, edge_out, half_period_out} !== 10'd0) begin errors++; $display("[TB] FAIL idle_quiet: got %h expected 0", {locked_out, edge_out, half_period_out}); end
    endtask

    // First rise is the reference, second (falling) edge is the first measurement.
    task automatic test_latency;
        @(negedge clk_in);
        sig_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (edge_out !== 1'b0) begin errors++; $display("[TB] FAIL lat_k: got %b expected 0", edge_out); end
        @(negedge clk_in);
        checks++;
        if (edge_out !== 1'b0) begin errors++; $display("[TB] FAIL lat_k1: got %b expected 0", edge_out); end
        @(negedge clk_in);
        checks++;
        if ({edge_out, rise_out} !== 2'b11) begin errors++; $display("[TB] FAIL lat_k2_rise: got %b expected 11", {edge_out, rise_out}); end
        checks++;
        if (half_period_out !== 8'd0) begin errors++; $display("[TB] FAIL ref_no_update: got %0d expected 0", half_period_out); end
        @(negedge clk_in);
        checks++;
        if ({edge_out, rise_out} !== 2'b00) begin errors++; $display("[TB] FAIL lat_k3: got %b expected 00", {edge_out, rise_out}); end
        repeat (59) @(negedge clk_in);
        @(negedge clk_in);
        sig_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({edge_out, rise_out} !== 2'b10) begin errors++; $display("[TB] FAIL fall_edge: got %b expected 10", {edge_out, rise_out}); end
        checks++;
        if (half_period_out !== 8'd64) begin errors++; $display("[TB] FAIL first_meas: got %0d expected 64", half_period_out); end
        repeat (60) @(negedge clk_in);
    endtask

    task automatic test_clean_lock;
        int base_err;
        half_period(64);
        half_period(64);
        checks++;
        if (locked_out !== 1'b0) begin errors++; $display("[TB] FAIL lock_early: got %b expected 0", locked_out); end
        half_period(64);
        checks++;
        if (locked_out !== 1'b1) begin errors++; $display("[TB] FAIL lock_5th: got %b expected 1", locked_out); end
        checks++;
        if (lock_rise_edge !== 5) begin errors++; $display("[TB] FAIL lock_edge_idx: got %0d expected 5", lock_rise_edge); end
        base_err = err_pulses;
        for (int i = 0; i < 100; i++) half_period(64);
        checks++;
        if (err_pulses !== base_err) begin errors++; $display("[TB] FAIL clean_no_err: got %0d expected %0d", err_pulses, base_err); end
        checks++;
        if ({locked_out, half_period_out} !== {1'b1, 8'd64}) begin errors++; $display("[TB] FAIL clean_hold: got %h expected 140", {locked_out, half_period_out}); end
    endtask

    task automatic test_tolerance;
        int base_err;
        base_err = err_pulses;
        half_period(60);
        half_period(68);
        half_period(64);
        checks++;
        if (half_period_out !== 8'd68) begin errors++; $display("[TB] FAIL tol_68_hp: got %0d expected 68", half_period_out); end
        checks++;
        if ({locked_out, error_out} !== 2'b10 || err_pulses !== base_err) begin errors++; $display("[TB] FAIL tol_edges_locked: got locked=%b errs=%0d expected 1 %0d", locked_out, err_pulses, base_err); end
        half_period(69);
        half_period(64);
        checks++;
        if (half_period_out !== 8'd69) begin errors++; $display("[TB] FAIL tol_69_hp: got %0d expected 69", half_period_out); end
        checks++;
        if (locked_out !== 1'b0 || err_pulses !== base_err + 1) begin errors++; $display("[TB] FAIL tol_69_err: got locked=%b errs=%0d expected 0 %0d", locked_out, err_pulses, base_err + 1); end
        half_period(64);
        half_period(64);
        half_period(64);
        checks++;
        if (locked_out !== 1'b0) begin errors++; $display("[TB] FAIL relock_early: got %b expected 0", locked_out); end
        half_period(64);
        checks++;
        if (locked_out !== 1'b1) begin errors++; $display("[TB] FAIL relock: got %b expected 1", locked_out); end
    endtask

    task automatic test_stuck;
        int base_err;
        if (sig_in == 1'b1) half_period(64);
        base_err = err_pulses;
        @(negedge clk_in);
        sig_in = 1'b1;
        repeat (71) @(negedge clk_in);
        checks++;
        if ({locked_out, error_out} !== 2'b10) begin errors++; $display("[TB] FAIL stuck_68: got %b expected 10", {locked_out, error_out}); end
        @(negedge clk_in);
        checks++;
        if ({locked_out, error_out} !== 2'b01) begin errors++; $display("[TB] FAIL stuck_69: got %b expected 01", {locked_out, error_out}); end
        checks++;
        if (half_period_out !== 8'd64) begin errors++; $display("[TB] FAIL stuck_hp: got %0d expected 64", half_period_out); end
        @(negedge clk_in);
        checks++;
        if (error_out !== 1'b0 || err_pulses !== base_err + 1) begin errors++; $display("[TB] FAIL stuck_pulse: got err=%b count=%0d expected 0 %0d", error_out, err_pulses, base_err + 1); end
        repeat (20) @(negedge clk_in);
        @(negedge clk_in);
        sig_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({edge_out, half_period_out} !== {1'b1, 8'd64}) begin errors++; $display("[TB] FAIL idle_ref_hp: got %h expected 140", {edge_out, half_period_out}); end
        repeat (60) @(negedge clk_in);
        for (int i = 0; i < 4; i++) half_period(64);
        checks++;
        if (locked_out !== 1'b1) begin errors++; $display("[TB] FAIL stuck_relock: got %b expected 1", locked_out); end
    endtask

    task automatic test_glitch;
        int base_err;
        if (sig_in == 1'b1) half_period(64);
        base_err = err_pulses;
        half_period(30);
        @(negedge clk_in);
        sig_in = 1'b0;
        @(negedge clk_in);
        sig_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++;
        if (half_period_out !== 8'd1) begin errors++; $display("[TB] FAIL glitch_hp: got %0d expected 1", half_period_out); end
        checks++;
        if (locked_out !== 1'b0 || err_pulses !== base_err + 1) begin errors++; $display("[TB] FAIL glitch_err: got locked=%b errs=%0d expected 0 %0d", locked_out, err_pulses, base_err + 1); end
        repeat (29) @(negedge clk_in);
        half_period(64);
        checks++;
        if (half_period_out !== 8'd33) begin errors++; $display("[TB] FAIL glitch_tail: got %0d expected 33", half_period_out); end
        half_period(64);
        half_period(64);
        half_period(64);
        checks++;
        if (locked_out !== 1'b0) begin errors++; $display("[TB] FAIL glitch_relock_early: got %b expected 0", locked_out); end
        half_period(64);
        checks++;
        if (locked_out !== 1'b1 || err_pulses !== base_err + 1) begin errors++; $display("[TB] FAIL glitch_relock: got locked=%b errs=%0d expected 1 %0d", locked_out, err_pulses, base_err + 1); end
    endtask

    task automatic test_reset_locked;
        int base_err;
        int base_edges;
        if (sig_in == 1'b1) half_period(64);
        base_err = err_pulses;
        @(negedge clk_in);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        checks++;
        if ({locked_out, error_out, edge_out, rise_out, half_period_out} !== 12'd0) begin errors++; $display("[TB] FAIL rst_lock_outs: got %h expected 0", {locked_out, error_out, edge_out, rise_out, half_period_out}); end
        base_edges = edge_count;
        repeat (5) @(negedge clk_in);
        checks++;
        if (err_pulses !== base_err) begin errors++; $display("[TB] FAIL rst_no_err: got %0d expected %0d", err_pulses, base_err); end
        for (int i = 0; i < 4; i++) half_period(64);
        checks++;
        if (locked_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_relock_early: got %b expected 0", locked_out); end
        half_period(64);
        checks++;
        if (locked_out !== 1'b1 || lock_rise_edge !== base_edges + 5) begin errors++; $display("[TB] FAIL rst_relock: got locked=%b edge=%0d expected 1 %0d", locked_out, lock_rise_edge, base_edges + 5); end
    endtask

    task automatic test_error_shape;
        checks++;
        if (err_wide !== 0) begin errors++; $display("[TB] FAIL err_width: got %0d wide pulses expected 0", err_wide); end
        checks++;
        if (err_incoherent !== 0) begin errors++; $display("[TB] FAIL err_vs_lock: got %0d incoherent expected 0", err_incoherent); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_clean_lock;
        test_tolerance;
        test_stuck;
        test_glitch;
        test_reset_locked;
        test_error_shape;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
